// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the multi-channel LED driver.
// Mode encoding is fixed because software writes it directly.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ON     = 2'd1,
    BLINK  = 2'd2,
    MIRROR = 2'd3
  } mode_t;

  localparam int DEFAULT_RESET_HALF = 500;

  // Clock cycles per shared tick; callers keep the ratio an integer >= 2.
  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Configuration write port of the LED driver.
// Protocol: no backpressure and no ready; every cycle with cfg_we high is one accepted write.
interface led_cfg_if
  import led_ctrl_pkg::*;
#(
  parameter int CH_W   = 3,
  parameter int HALF_W = 16
) ();

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  mode_t             cfg_mode;
  logic [HALF_W-1:0] cfg_half;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_mode,
    output cfg_half
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_mode,
    input cfg_half
  );

endinterface

// File: rtl/led_blink_ctrl_channel.sv
// One LED channel: stored mode/half-period, blink counter, mirror synchroniser and LED register.
// A write updates mode/half and clears cnt; the LED reflects the new mode one edge later.
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int    HALF_W     = 16,
  parameter mode_t RESET_MODE = BLINK,
  parameter int    RESET_HALF = DEFAULT_RESET_HALF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              tick,
  input  logic              wr,
  input  mode_t             cfg_mode,
  input  logic [HALF_W-1:0] cfg_half,
  input  logic              mirror_in,
  output logic              led
);

  mode_t             mode_q, mode_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic [HALF_W-1:0] lim;
  logic              led_q, led_d;
  logic              start_q;
  logic [1:0]        sync_q;

  // A half-period of zero behaves like one tick.
  assign lim = (half_q == '0) ? '0 : (half_q - HALF_W'(1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q  <= RESET_MODE;
      half_q  <= HALF_W'(RESET_HALF);
      cnt_q   <= '0;
      led_q   <= 1'b0;
      start_q <= 1'b0;
      sync_q  <= 2'b00;
    end else begin
      mode_q  <= mode_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      start_q <= wr;
      sync_q  <= {sync_q[0], mirror_in};
    end
  end

  always_comb begin
    mode_d = mode_q;
    half_d = half_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    if (wr) begin
      // The write owns this edge: a coincident tick is dropped and the LED holds.
      mode_d = cfg_mode;
      half_d = cfg_half;
      cnt_d  = '0;
    end else begin
      unique case (mode_q)
        OFF:    led_d = 1'b0;
        ON:     led_d = 1'b1;
        MIRROR: led_d = sync_q[1];
        BLINK: begin
          if (tick) begin
            if (cnt_q == lim) begin
              cnt_d = '0;
              led_d = ~led_q;
            end else begin
              cnt_d = cnt_q + HALF_W'(1);
            end
          end
          // A freshly written blink always starts in the lit phase.
          if (start_q) led_d = 1'b1;
        end
        default: led_d = led_q;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver top: shared tick prescaler, write decoder and one led_channel per output.
// Every output comes straight from a flop, so no input reaches led or tick combinationally.
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int    NUM_CH      = 8,
  parameter int    CLK_FREQ_HZ = 100_000_000,
  parameter int    TICK_HZ     = 1_000,
  parameter int    HALF_W      = 16,
  parameter mode_t RESET_MODE  = BLINK,
  parameter int    RESET_HALF  = DEFAULT_RESET_HALF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  led_cfg_if.slave          cfg,
  input  logic [NUM_CH-1:0] mirror_in,
  output logic [NUM_CH-1:0] led,
  output logic              tick
);

  localparam int TICK_DIV = tick_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int PRE_W    = $clog2(TICK_DIV);
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tick_q;
  logic [NUM_CH-1:0] wr;

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (pre_q == PRE_W'(TICK_DIV - 1)) pre_d = '0;
  end

  // tick is registered one count early so it is high exactly while the prescaler holds TICK_DIV-1.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= (pre_q == PRE_W'(TICK_DIV - 2));
    end
  end

  assign tick = tick_q;

  // Indices with no matching channel decode to no write at all.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

    led_channel #(
      .HALF_W     (HALF_W),
      .RESET_MODE (RESET_MODE),
      .RESET_HALF (RESET_HALF)
    ) u_channel (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .tick      (tick_q),
      .wr        (wr[i]),
      .cfg_mode  (cfg.cfg_mode),
      .cfg_half  (cfg.cfg_half),
      .mirror_in (mirror_in[i]),
      .led       (led[i])
    );
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl: 4-channel build (tick every 10 cycles, reset half 3)
// plus a 3-channel build that receives a write to the non-existent channel 3.
module tb_led_blink_ctrl;
  import led_ctrl_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] mirror_in = '0;
  logic [2:0] mirror3 = '0;
  logic [3:0] led;
  logic [2:0] led3;
  logic       tick;
  logic       tick3;
  int         cyc;
  int         checks = 0;
  int         errors = 0;

  led_cfg_if #(.CH_W(2), .HALF_W(16)) cfg  ();
  led_cfg_if #(.CH_W(2), .HALF_W(16)) cfg3 ();

  led_blink_ctrl #(
    .NUM_CH(4), .CLK_FREQ_HZ(10_000), .TICK_HZ(1_000), .HALF_W(16),
    .RESET_MODE(BLINK), .RESET_HALF(3)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg(cfg),
    .mirror_in(mirror_in), .led(led), .tick(tick)
  );

  led_blink_ctrl #(
    .NUM_CH(3), .CLK_FREQ_HZ(10_000), .TICK_HZ(1_000), .HALF_W(16),
    .RESET_MODE(BLINK), .RESET_HALF(3)
  ) dut3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg(cfg3),
    .mirror_in(mirror3), .led(led3), .tick(tick3)
  );

  // clock / reset-relative cycle counter
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // driver tasks
  task automatic goto(input int e);
    while (cyc < e) @(negedge sys_clk);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input mode_t m, input logic [15:0] h);
    cfg.cfg_we = 1'b1; cfg.cfg_ch = ch; cfg.cfg_mode = m; cfg.cfg_half = h;
    @(negedge sys_clk);
    cfg.cfg_we = 1'b0;
  endtask

  task automatic cfg3_write(input logic [1:0] ch, input mode_t m, input logic [15:0] h);
    cfg3.cfg_we = 1'b1; cfg3.cfg_ch = ch; cfg3.cfg_mode = m; cfg3.cfg_half = h;
    @(negedge sys_clk);
    cfg3.cfg_we = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s at cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
  endtask

  initial begin
    cfg.cfg_we = 1'b0;  cfg.cfg_ch = '0;  cfg.cfg_mode = OFF;  cfg.cfg_half = '0;
    cfg3.cfg_we = 1'b0; cfg3.cfg_ch = '0; cfg3.cfg_mode = OFF; cfg3.cfg_half = '0;

    // reset and free-running blink
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b0;
    check("rst_led", 32'(led), 32'h0);
    check("rst_led3", 32'(led3), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    goto(8);  check("tick_c8", 32'(tick), 32'h0);
    goto(9);  check("tick_c9", 32'(tick), 32'h1);
    check("tick3_c9", 32'(tick3), 32'h1);
    goto(10); check("tick_c10", 32'(tick), 32'h0);

    // out-of-range channel on the 3-channel build must change nothing
    cfg3_write(2'd3, OFF, 16'd1);
    goto(29); check("pre_rise", 32'(led), 32'h0);
    check("pre_rise3", 32'(led3), 32'h0);
    goto(30); check("rise_c30", 32'(led), 32'hf);
    check("inval_ch3", 32'(led3), 32'h7);

    // modes
    cfg_write(2'd1, ON, 16'd3);
    cfg_write(2'd2, OFF, 16'd3);
    check("off_hold", 32'(led), 32'hf);
    cfg_write(2'd3, MIRROR, 16'd3);
    check("off_c33", 32'(led), 32'hb);
    goto(34); check("mirror_c34", 32'(led), 32'h3);
    goto(40); mirror_in[3] = 1'b1;
    goto(42); check("mirror_lat2", 32'(led), 32'h3);
    goto(43); check("mirror_lat3", 32'(led), 32'hb);
    goto(50); mirror_in[3] = 1'b0;
    goto(52); check("mirror_fall2", 32'(led), 32'hb);
    goto(53); check("mirror_fall3", 32'(led), 32'h3);
    goto(59); check("phase_c59", 32'(led), 32'h3);
    goto(60); check("phase_c60", 32'(led), 32'h2);
    check("phase3_c60", 32'(led3), 32'h0);

    // half-period 5, then 0
    cfg_write(2'd0, BLINK, 16'd5);
    check("wr_hold", 32'(led), 32'h2);
    goto(62);  check("blink_start", 32'(led), 32'h3);
    goto(109); check("h5_c109", 32'(led), 32'h3);
    goto(110); check("h5_c110", 32'(led), 32'h2);
    goto(159); check("h5_c159", 32'(led), 32'h2);
    goto(160); check("h5_c160", 32'(led), 32'h3);
    cfg_write(2'd0, BLINK, 16'd0);
    goto(162); check("h0_start", 32'(led), 32'h3);
    goto(169); check("h0_c169", 32'(led), 32'h3);
    goto(170); check("h0_c170", 32'(led), 32'h2);
    goto(179); check("h0_c179", 32'(led), 32'h2);
    goto(180); check("h0_c180", 32'(led), 32'h3);

    // write lands on the tick edge
    goto(189); check("coll_tick", 32'(tick), 32'h1);
    cfg_write(2'd0, BLINK, 16'd2);
    check("coll_c190", 32'(led), 32'h3);
    goto(200); check("coll_c200", 32'(led), 32'h3);
    goto(209); check("coll_c209", 32'(led), 32'h3);
    goto(210); check("coll_c210", 32'(led), 32'h2);

    // asynchronous reset between edges
    goto(215);
    #2 sys_rst = 1'b1;
    #1;
    check("arst_led", 32'(led), 32'h0);
    check("arst_led3", 32'(led3), 32'h0);
    check("arst_tick", 32'(tick), 32'h0);
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b0;
    check("rel_led", 32'(led), 32'h0);
    goto(9);  check("rel_tick", 32'(tick), 32'h1);
    goto(29); check("rel_c29", 32'(led), 32'h0);
    goto(30); check("rel_c30", 32'(led), 32'hf);
    check("rel3_c30", 32'(led3), 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
